// File: rtl/weight_stream_fifo_if.sv
// rtl/weight_stream_fifo_if.sv - input-word and output-element handshake bundle for weight_stream_fifo
interface weight_stream_fifo_if #(
  parameter int IN_W   = 32,
  parameter int ELEM_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/weight_stream_fifo.sv
// rtl/weight_stream_fifo.sv - width-converting weight FIFO, IN_W words in, ELEM_W elements out
// Optional kernel replay enabled by defining WGT_BUF_REPLAY_EN.
module weight_stream_fifo #(
  parameter  int IN_W   = 32,
  parameter  int ELEM_W = 16,
  parameter  int DEPTH  = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  weight_stream_fifo_if.slave s_if,
  output logic [CNT_W-1:0] o_count
`ifdef WGT_BUF_REPLAY_EN
  ,
  input  logic [CNT_W-1:0] i_kern_len,
  input  logic [7:0]       i_reuse_num
`endif
);

  localparam int RATIO = IN_W / ELEM_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ELEM_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_in_ready;
  logic              w_out_valid;
  logic [CNT_W-1:0]  w_dec;

  // in_ready depends only on the registered occupancy, never on out_ready
  assign w_in_ready = (r_count <= (DEPTH_C - RATIO_C));
  assign w_push     = s_if.in_valid & w_in_ready;
  assign w_pop      = w_out_valid & s_if.out_ready;

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = w_out_valid;
  assign s_if.out_data  = r_mem[r_rd_ptr];
  assign o_count        = r_count;

`ifdef WGT_BUF_REPLAY_EN
  localparam logic [0:0] ST_PASS   = 1'b0;
  localparam logic [0:0] ST_REWIND = 1'b1;

  logic [0:0]       r_state;
  logic [PTR_W-1:0] r_cm_ptr;
  logic [CNT_W-1:0] r_rd_off;
  logic [7:0]       r_pass_cnt;
  logic             r_started;
  logic [CNT_W-1:0] r_klen;
  logic [7:0]       r_reuse;

  logic [CNT_W-1:0] w_klen;
  logic [7:0]       w_reuse;
  logic             w_last;
  logic             w_free;

  // kernel parameters are latched on the first pop and held until the kernel is freed
  assign w_klen      = r_started ? r_klen  : i_kern_len;
  assign w_reuse     = r_started ? r_reuse : i_reuse_num;
  assign w_out_valid = (r_state == ST_PASS) && (r_count >= w_klen);
  assign w_last      = w_pop && (r_rd_off == (w_klen - CNT_W'(1)));
  assign w_free      = w_last && (r_pass_cnt >= w_reuse);
  assign w_dec       = w_free ? w_klen : '0;
`else
  assign w_out_valid = (r_count != '0);
  assign w_dec       = w_pop ? CNT_W'(1) : '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
`ifdef WGT_BUF_REPLAY_EN
      r_state    <= ST_PASS;
      r_cm_ptr   <= '0;
      r_rd_off   <= '0;
      r_pass_cnt <= '0;
      r_started  <= 1'b0;
      r_klen     <= '0;
      r_reuse    <= '0;
`endif
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
`ifdef WGT_BUF_REPLAY_EN
      r_state    <= ST_PASS;
      r_cm_ptr   <= '0;
      r_rd_off   <= '0;
      r_pass_cnt <= '0;
      r_started  <= 1'b0;
`endif
    end else begin
      // element-wise write so a word straddling the wrap splits cleanly
      if (w_push) begin
        for (int k = 0; k < RATIO; k++)
          r_mem[r_wr_ptr + PTR_W'(k)] <= s_if.in_data[k*ELEM_W +: ELEM_W];
        r_wr_ptr <= r_wr_ptr + PTR_W'(RATIO);
      end
      r_count <= r_count + (w_push ? RATIO_C : '0) - w_dec;
`ifdef WGT_BUF_REPLAY_EN
      case (r_state)
        ST_PASS: begin
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (!r_started) begin
              r_started <= 1'b1;
              r_klen    <= i_kern_len;
              r_reuse   <= i_reuse_num;
            end
            if (w_last) begin
              r_rd_off <= '0;
              if (w_free) begin
                r_cm_ptr   <= r_cm_ptr + w_klen[PTR_W-1:0];
                r_pass_cnt <= '0;
                r_started  <= 1'b0;
              end else begin
                r_pass_cnt <= r_pass_cnt + 8'd1;
                r_state    <= ST_REWIND;
              end
            end else begin
              r_rd_off <= r_rd_off + CNT_W'(1);
            end
          end
        end
        default: begin
          r_rd_ptr <= r_cm_ptr;
          r_state  <= ST_PASS;
        end
      endcase
`else
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
`endif
    end
  end

endmodule
